imem_loadable: RTL and testbench
================================

// Module: imem_loadable
// PURPOSE
//  Parametrised instruction memory for the RV32I core: word-addressed storage with a
//  registered 1-cycle fetch port, a post-reset hardware clear, and a byte-serial
//  program-load port (UART-style) that packs little-endian bytes into words.
//  Sits between the core fetch stage and the boot/loader link.
// PARAMETERS
//  DEPTH      64            number of 32-bit words (power of two, >=4)
//  ADDR_W     6             log2(DEPTH)
//  FILL_WORD  32'h00000013  clear/fault value (addi x0,x0,0 NOP)
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-low reset
//  fetch_req      in   1         fetch request, sampled when ready=1
//  fetch_addr     in   32        byte address of instruction
//  fetch_valid    out  1         instr/fetch_fault valid this cycle
//  instr          out  32        fetched word
//  fetch_fault    out  1         addr misaligned (a[1:0]!=0) or >= DEPTH*4
//  load_start     in   1         begin (or restart) program load at word 0
//  load_byte      in   8         load data byte
//  load_byte_vld  in   1         load_byte valid strobe
//  load_end       in   1         terminate load
//  load_count     out  ADDR_W+1  words written by current/last load
//  load_ovf       out  1         sticky: bytes arrived with memory full
//  ready          out  1         1 in RUN state only
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=CLEAR, clr_ptr=0, byte lane=0; outputs
//   fetch_valid=0, instr=0, fetch_fault=0, load_count=0, load_ovf=0, ready=0.
//   Reset mid-LOAD aborts the load; contents are re-cleared.
//  States: CLEAR -> RUN -> LOAD -> RUN.
//  CLEAR: writes FILL_WORD to mem[clr_ptr] each cycle, clr_ptr++; after word
//   DEPTH-1 written, next cycle RUN, ready=1. Duration exactly DEPTH cycles.
//   All inputs ignored.
//  RUN: fetch_req=1 at edge n -> at edge n+1 fetch_valid=1 and
//   instr=mem[fetch_addr[ADDR_W+1:2]], fetch_fault=0; if fault, instr=FILL_WORD,
//   fetch_fault=1. No req -> fetch_valid=0, instr holds last value.
//   Back-to-back requests give one result per cycle.
//   load_start=1 -> LOAD next cycle; load_count=0, load_ovf=0, lane=0;
//   a fetch_req in that same cycle is still served.
//  LOAD: ready=0, fetch_req ignored, fetch_valid=0.
//   Each load_byte_vld places load_byte in lane (lane 0 -> [7:0] ... lane 3 ->
//   [31:24]); lane++ mod 4. On lane-3 byte the assembled word is written to
//   mem[load_count] same edge, load_count++.
//   load_count==DEPTH: further bytes dropped, load_ovf=1 (sticky until next
//   load_start); state stays LOAD until load_end.
//   load_end=1 -> RUN next cycle. Partial word (lane!=0) is written with the
//   missing upper bytes zero and counted. load_byte_vld with load_end in the
//   same cycle: byte accepted first, then terminate.
//   load_start in LOAD: restart at word 0 (count, lane, ovf cleared); prior
//   words remain. load_start and load_end together: load_start wins.
//  Memory contents survive LOAD->RUN; only reset clears.
// TESTING
//  Reset 1 cyc, release -> ready=0 for 64 cycles then 1; fetch 0x0..0xFC all
//   return 0x00000013, fault=0.
//  Load bytes 93 00 00 00 13 01 10 00, load_end -> load_count=2; fetch 0x0 ->
//   0x00000093, fetch 0x4 -> 0x00100113, each 1 cycle after req.
//  Fetch 0x2 -> fault=1, instr=0x13; fetch 0x100 -> fault=1; back-to-back
//   0x0,0x4 -> valid on two consecutive cycles.
//  Load 257 bytes into DEPTH=64 -> load_count=64, load_ovf=1; next load_start
//   clears ovf.
//  Load 3 bytes 63 5c a0 then load_end with a 4th byte 00 same cycle ->
//   word0=0x00a05c63, count=1; 2 bytes 6f f0 then load_end -> word=0x0000f06f.
//  Drop reset mid-LOAD -> ready=0, 64-cycle clear, fetch 0x0 -> 0x13.

Source files
------------

// File: rtl/imem_loadable.sv
// Instruction memory for the RV32I core: registered 1-cycle fetch port, post-reset
// fill with a NOP word, and a byte-serial loader that packs little-endian bytes into words.
module imem_loadable #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] FILL_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       instr,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_vld,
    input  logic              load_end,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf,
    output logic              ready
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              fetch_valid_q;
    logic [31:0]       instr_q;
    logic              fault_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       asm_word;
    logic [1:0]        lane_nx;
    logic              accept;

    logic              fetch_go;
    logic              fetch_bad;
    logic [ADDR_W-1:0] fetch_idx;

    assign fetch_go  = (state_q == ST_RUN) && fetch_req;
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:ADDR_W+2]);
    assign fetch_idx = fetch_addr[ADDR_W+1:2];

    // Single write port shared by the clear sweep and the loader.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            lane_q        <= '0;
            buf_q         <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            instr_q       <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            lane_q        <= lane_d;
            buf_q         <= buf_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            fetch_valid_q <= fetch_go;
            if (fetch_go) begin
                fault_q <= fetch_bad;
                instr_q <= fetch_bad ? FILL_WORD : mem[fetch_idx];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        asm_word  = {8'h00, buf_q};
        lane_nx   = lane_q;
        accept    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = reset;
                mem_waddr = clr_ptr_q;
                mem_wdata = FILL_WORD;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    lane_d  = '0;
                    buf_d   = '0;
                end
            end

            ST_LOAD: begin
                if (load_start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    lane_d  = '0;
                    buf_d   = '0;
                end else begin
                    if (load_byte_vld) begin
                        if (count_q == COUNT_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            accept = 1'b1;
                        end
                    end
                    if (accept) begin
                        asm_word[8*lane_q +: 8] = load_byte;
                        lane_nx                 = lane_q + 2'd1;
                    end
                    // A byte arriving with load_end lands first, so a partial word
                    // may include it; upper lanes stay zero because buf is cleared per word.
                    if ((accept && lane_q == 2'd3) || (load_end && lane_nx != 2'd0)) begin
                        mem_we    = reset;
                        mem_waddr = count_q[ADDR_W-1:0];
                        mem_wdata = asm_word;
                        count_d   = count_q + (ADDR_W + 1)'(1);
                        lane_d    = '0;
                        buf_d     = '0;
                    end else if (accept) begin
                        lane_d = lane_nx;
                        buf_d  = asm_word[23:0];
                    end
                    if (load_end) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign fetch_valid = fetch_valid_q;
    assign instr       = instr_q;
    assign fetch_fault = fault_q;
    assign load_count  = count_q;
    assign load_ovf    = ovf_q;
    assign ready       = (state_q == ST_RUN);

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboarded bench for imem_loadable: fetch expectations are queued when a request
// is driven and checked when fetch_valid appears.
module tb_imem_loadable;

    localparam int DEPTH = 64;
    localparam int ADDR_W = 6;
    localparam logic [31:0] FILL = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic              fetch_valid;
    logic [31:0]       instr;
    logic              fetch_fault;
    logic              load_start = 1'b0;
    logic [7:0]        load_byte = '0;
    logic              load_byte_vld = 1'b0;
    logic              load_end = 1'b0;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic              ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [32:0] sb_q [$];

    imem_loadable #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL_WORD(FILL)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .instr        (instr),
        .fetch_fault  (fetch_fault),
        .load_start   (load_start),
        .load_byte    (load_byte),
        .load_byte_vld(load_byte_vld),
        .load_end     (load_end),
        .load_count   (load_count),
        .load_ovf     (load_ovf),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] expect_of(input logic [31:0] a);
        logic bad;
        bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        return bad ? {1'b1, FILL} : {1'b0, model_mem[a[ADDR_W+1:2]]};
    endfunction

    function automatic logic [7:0] big_byte(input int i);
        return 8'((i * 37) + 5);
    endfunction

    // Scoreboard consumer: every valid result must match the oldest queued request.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 64'(fetch_valid), 64'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                $display("fetch result instr=0x%08h fault=%0b", instr, fetch_fault);
                check("fetch_instr", 64'(instr), 64'(e[31:0]));
                check("fetch_fault", 64'(fetch_fault), 64'(e[32]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        sb_q.push_back(expect_of(a));
        step();
        fetch_req = 1'b0;
    endtask

    task automatic lstart();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic lbyte(input logic [7:0] b, input logic with_end);
        load_byte     = b;
        load_byte_vld = 1'b1;
        load_end      = with_end;
        step();
        load_byte_vld = 1'b0;
        load_end      = 1'b0;
    endtask

    task automatic lend();
        load_end = 1'b1;
        step();
        load_end = 1'b0;
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b0;
        step();
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_fetch_fault", 64'(fetch_fault), 64'd0);
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_load_ovf", 64'(load_ovf), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        check("clear_cycles", 64'(n), 64'd64);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // Whole array reads back as the fill word after clear.
        for (int i = 0; i < DEPTH; i++) fetch(32'(i * 4));
        step(); step();

        // Two-word program.
        lstart();
        check("ready_in_load", 64'(ready), 64'd0);
        lbyte(8'h93, 1'b0); lbyte(8'h00, 1'b0);
        fetch_req = 1'b1; fetch_addr = 32'h0;   // must be ignored while loading
        lbyte(8'h00, 1'b0);
        fetch_req = 1'b0;
        lbyte(8'h00, 1'b0);
        lbyte(8'h13, 1'b0); lbyte(8'h01, 1'b0); lbyte(8'h10, 1'b0); lbyte(8'h00, 1'b0);
        lend();
        model_mem[0] = 32'h0000_0093;
        model_mem[1] = 32'h0010_0113;
        check("load2_count", 64'(load_count), 64'd2);
        check("load2_ready", 64'(ready), 64'd1);
        fetch(32'h0); step();
        fetch(32'h4); step();

        // Faults and back-to-back.
        fetch(32'h2);
        fetch(32'h100);
        fetch(32'hFFFF_FFFC);
        step();
        fetch(32'h0);
        check("b2b_valid0", 64'(fetch_valid), 64'd1);
        fetch(32'h4);
        check("b2b_valid1", 64'(fetch_valid), 64'd1);
        step(); step();

        // Overflow: 257 bytes into 64 words.
        lstart();
        for (int i = 0; i < 256; i++) lbyte(big_byte(i), 1'b0);
        check("full_count", 64'(load_count), 64'd64);
        check("full_no_ovf", 64'(load_ovf), 64'd0);
        lbyte(8'hEE, 1'b0);
        check("ovf_set", 64'(load_ovf), 64'd1);
        check("ovf_still_load", 64'(ready), 64'd0);
        lend();
        for (int k = 0; k < DEPTH; k++)
            model_mem[k] = {big_byte(4*k+3), big_byte(4*k+2), big_byte(4*k+1), big_byte(4*k)};
        check("ovf_count_after", 64'(load_count), 64'd64);
        check("ovf_sticky", 64'(load_ovf), 64'd1);
        fetch(32'h0); fetch(32'h7C); fetch(32'hFC);
        step(); step();

        // load_start together with a fetch: the fetch is still served.
        fetch_req = 1'b1; fetch_addr = 32'h4;
        sb_q.push_back(expect_of(32'h4));
        lstart();
        fetch_req = 1'b0;
        check("restart_ovf_clr", 64'(load_ovf), 64'd0);
        check("restart_count_clr", 64'(load_count), 64'd0);

        // Three bytes, then fourth byte together with load_end.
        lbyte(8'h63, 1'b0); lbyte(8'h5c, 1'b0); lbyte(8'ha0, 1'b0);
        lbyte(8'h00, 1'b1);
        model_mem[0] = 32'h00a0_5c63;
        check("end_byte_count", 64'(load_count), 64'd1);
        check("end_byte_ready", 64'(ready), 64'd1);
        fetch(32'h0); fetch(32'h4);
        step(); step();

        // Partial word zero-filled.
        lstart();
        lbyte(8'h6f, 1'b0); lbyte(8'hf0, 1'b0);
        lend();
        model_mem[0] = 32'h0000_f06f;
        check("partial_count", 64'(load_count), 64'd1);
        fetch(32'h0); fetch(32'h4);
        step(); step();

        // Restart inside LOAD with load_end asserted: start wins.
        lstart();
        lbyte(8'h11, 1'b0);
        load_start = 1'b1; load_end = 1'b1;
        step();
        load_start = 1'b0; load_end = 1'b0;
        check("start_wins_ready", 64'(ready), 64'd0);
        check("start_wins_count", 64'(load_count), 64'd0);
        lbyte(8'h22, 1'b1);
        model_mem[0] = 32'h0000_0022;
        check("start_wins_final", 64'(load_count), 64'd1);
        fetch(32'h0);
        step(); step();

        // Reset during LOAD aborts and re-clears.
        lstart();
        lbyte(8'hAA, 1'b0); lbyte(8'hBB, 1'b0);
        do_reset();
        fetch(32'h0); fetch(32'h4); fetch(32'hFC);
        step(); step(); step();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
